sc_et_counter: RTL and testbench
================================

# sc_et_counter

Stochastic-to-binary counter with deterministic early termination, placed directly downstream of the LFSR stochastic number generator. It consumes one stochastic bitstream, one SNG `Xs` lane, at one bit per valid cycle. It counts ones over a stream of at most `STREAM_LEN` bits and decides whether the encoded value exceeds a programmed threshold. It stops as soon as the remaining bits can no longer change that decision. It reports the decision, the ones count, the number of bits consumed and whether termination was early.

## Interface
Clock is `clk`. Reset `rst_n` is asynchronous and active-low. One clock domain.

- `STREAM_LEN`, default 255: maximum stream length in bits; matches the 8-bit LFSR period.
- `ET_EN`, default 1: 1 enables early termination; 0 always consumes `STREAM_LEN` bits.
- `CW`, default `$clog2(STREAM_LEN+1)`: counter width. Derived; do not override.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `start`  in  1  begin a measurement; honoured only in IDLE
- `thresh`  in  CW  ones-count threshold T; captured on accepted `start`
- `x`  in  1  stochastic bit from the SNG lane
- `x_valid`  in  1  `x` is a valid stream bit this cycle
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse when a result is ready
- `decision`  out  1  1 = value exceeds T (ones > T)
- `early`  out  1  1 = terminated before `STREAM_LEN` bits
- `ones`  out  CW  ones counted
- `cycles`  out  CW  valid bits consumed

## Operation
- **States:** IDLE, RUN and DONE.
- **IDLE, `start`=1:** latch `thresh` into T. Clear `ones`, `cycles`, `decision` and `early`. Go to RUN. `start` outside IDLE is ignored.
- **RUN, `x_valid`=0:** nothing changes (stall).
- **RUN, `x_valid`=1:** the sample is accepted.
  - c' = `cycles`+1.
  - o' = `ones`+`x`.
  - Register c' and o'.
- **Termination checks.** They are evaluated on c'/o' of each accepted sample, in priority order:
  1. `ET_EN` and o' > T: `decision`=1, `early`=(c' < `STREAM_LEN`), go to DONE.
  2. `ET_EN` and o' + (`STREAM_LEN` − c') ≤ T: `decision`=0, `early`=(c' < `STREAM_LEN`), go to DONE.
  3. c' == `STREAM_LEN`: `decision`=(o' > T), `early`=0, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then return to IDLE.
- **Holding results:** `ones`, `cycles`, `decision` and `early` hold until the next accepted `start`.
- **Arithmetic:** `ones` and `cycles` never exceed `STREAM_LEN`, so no wrap is possible. The remaining-bits sum o' + (`STREAM_LEN` − c') must be computed in CW+1 bits.
- **T ≥ `STREAM_LEN`:** with `ET_EN`=1, terminates on the first accepted sample with `decision`=0 and `early`=1, or `early`=0 when `STREAM_LEN`=1.
- **T = 0:** the first sample with `x`=1 terminates with `decision`=1.
- **Reset mid-RUN or mid-DONE:** abort immediately to IDLE with all outputs at reset values. No `done` pulse is issued.

## Timing
- **Reset values:** every output is 0 and the state is IDLE.
- **`start` acceptance:** `start` is sampled at a rising edge in IDLE; `busy` rises on that edge. The first sample that can be accepted is the one present in the following cycle.
- **Termination latency:** a terminating sample is accepted at edge k. At that edge the state becomes DONE, and `ones`, `cycles`, `decision` and `early` update. `done` is high during the cycle after edge k, and `busy` is low in that same cycle.
- **Back-to-back:** the earliest next `start` is sampled in the cycle after `done` (IDLE). Minimum spacing between two `start` acceptances is one sample plus 2 cycles.
- **Upstream SNG:** the SNG free-runs and has no enable. Stream alignment is the system's responsibility: gate `x_valid` or reset both blocks together.
- **Register outputs:** all outputs come straight from registers, with no combinational path from inputs to outputs.

## Test plan
All scenarios use defaults (`STREAM_LEN`=255, `ET_EN`=1) unless stated otherwise.

- **All-ones stream:** T=127, `x`=1, `x_valid`=1 every cycle → `done` after 128 accepted samples; `decision`=1, `ones`=128, `cycles`=128, `early`=1.
- **All-zeros stream:** T=127, `x`=0 → terminates at `cycles`=128 (0+127 ≤ 127); `decision`=0, `ones`=0, `early`=1.
- **Alternating stream:** T=127, `x`=1,0,1,… → runs the full 255 samples; `ones`=128, `decision`=1, `early`=0.
- **`ET_EN`=0:** all-ones stream, T=127 → `cycles`=255, `ones`=255, `decision`=1, `early`=0. Also drive `start` mid-RUN and check it is ignored.
- **Stalls:** all-ones stream, T=10, with `x_valid` toggling 1,0,1,0 → `cycles` advances only on valid samples. Terminates at `ones`=11, `cycles`=11; `done` is one cycle wide.
- **Reset mid-run:** pulse `rst_n` low after 50 samples → all outputs 0, IDLE, no `done`. A fresh `start` with T=0 and first `x`=1 → `done` with `decision`=1, `cycles`=1.

Source files
------------

// File: rtl/sc_et_counter_if.sv
// rtl/sc_et_counter_if.sv - control/stream/result bundle for the early-termination counter
interface sc_et_counter_if #(
  parameter int CW = 8
);
  logic          start;
  logic [CW-1:0] thresh;
  logic          x;
  logic          x_valid;
  logic          busy;
  logic          done;
  logic          decision;
  logic          early;
  logic [CW-1:0] ones;
  logic [CW-1:0] cycles;

  modport master (
    output start, thresh, x, x_valid,
    input  busy, done, decision, early, ones, cycles
  );

  modport slave (
    input  start, thresh, x, x_valid,
    output busy, done, decision, early, ones, cycles
  );
endinterface

// File: rtl/sc_et_counter.sv
// rtl/sc_et_counter.sv - stochastic-to-binary threshold counter with early termination
module sc_et_counter #(
  parameter int STREAM_LEN = 255,
  parameter bit ET_EN      = 1'b1,
  parameter int CW         = $clog2(STREAM_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  sc_et_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] LEN_C = CW'(STREAM_LEN);
  localparam logic [CW:0]   LEN_W = (CW + 1)'(STREAM_LEN);

  state_t        state_q;
  logic [CW-1:0] thresh_q;
  logic [CW-1:0] ones_q;
  logic [CW-1:0] cycles_q;
  logic          busy_q;
  logic          done_q;
  logic          decision_q;
  logic          early_q;

  logic [CW-1:0] ones_d;
  logic [CW-1:0] cycles_d;
  logic [CW:0]   reach_d;
  logic          hit_hi;
  logic          hit_lo;
  logic          hit_end;
  logic          early_d;

  // Post-sample counts; the best-case reachable ones count needs one extra bit.
  always_comb begin
    cycles_d = cycles_q + 1'b1;
    ones_d   = ones_q + {{(CW-1){1'b0}}, bus.x};
    reach_d  = {1'b0, ones_d} + LEN_W - {1'b0, cycles_d};
    hit_hi   = ET_EN && (ones_d > thresh_q);
    hit_lo   = ET_EN && (reach_d <= {1'b0, thresh_q});
    hit_end  = (cycles_d == LEN_C);
    early_d  = (cycles_d < LEN_C);
  end

  // Control FSM with all outputs registered; reset aborts any measurement silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      thresh_q   <= '0;
      ones_q     <= '0;
      cycles_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      decision_q <= 1'b0;
      early_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            thresh_q   <= bus.thresh;
            ones_q     <= '0;
            cycles_q   <= '0;
            decision_q <= 1'b0;
            early_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.x_valid) begin
            ones_q   <= ones_d;
            cycles_q <= cycles_d;
            if (hit_hi) begin
              decision_q <= 1'b1;
              early_q    <= early_d;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else if (hit_lo) begin
              decision_q <= 1'b0;
              early_q    <= early_d;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else if (hit_end) begin
              decision_q <= (ones_d > thresh_q);
              early_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.decision = decision_q;
  assign bus.early    = early_q;
  assign bus.ones     = ones_q;
  assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_sc_et_counter.sv
// tb/tb_sc_et_counter.sv - self-checking bench for sc_et_counter
module tb_sc_et_counter;

  localparam int LEN    = 255;
  localparam int CW     = $clog2(LEN + 1);
  localparam int BUDGET = 2000;

  logic clk;
  logic rst_n;
  logic sel;
  logic start;
  logic [CW-1:0] thresh;
  logic x;
  logic x_valid;

  logic o_busy, o_done, o_dec, o_early;
  logic [CW-1:0] o_ones, o_cycles;

  int n_checks;
  int n_errors;
  bit bits [0:255];

  sc_et_counter_if #(.CW(CW)) if0 ();
  sc_et_counter_if #(.CW(CW)) if1 ();

  sc_et_counter #(.STREAM_LEN(LEN), .ET_EN(1'b1)) u_et (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  sc_et_counter #(.STREAM_LEN(LEN), .ET_EN(1'b0)) u_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  assign if0.start   = (sel == 1'b0) ? start : 1'b0;
  assign if0.thresh  = thresh;
  assign if0.x       = x;
  assign if0.x_valid = (sel == 1'b0) ? x_valid : 1'b0;
  assign if1.start   = (sel == 1'b1) ? start : 1'b0;
  assign if1.thresh  = thresh;
  assign if1.x       = x;
  assign if1.x_valid = (sel == 1'b1) ? x_valid : 1'b0;

  assign o_busy   = sel ? if1.busy     : if0.busy;
  assign o_done   = sel ? if1.done     : if0.done;
  assign o_dec    = sel ? if1.decision : if0.decision;
  assign o_early  = sel ? if1.early    : if0.early;
  assign o_ones   = sel ? if1.ones     : if0.ones;
  assign o_cycles = sel ? if1.cycles   : if0.cycles;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int  t;
    int  pat;
    int  stall;
    bit  dut;
    bit  poke;
    int  e_ones;
    int  e_cycles;
    int  e_dec;
    int  e_early;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // pattern: 0 all ones, 1 all zeros, 2 alternating 1,0,..., 3 biased random
  task automatic fill(input int pat);
    int bias;
    bias = $urandom_range(0, 100);
    for (int i = 0; i < 256; i++) begin
      case (pat)
        0:       bits[i] = 1'b1;
        1:       bits[i] = 1'b0;
        2:       bits[i] = (i % 2 == 0);
        default: bits[i] = ($urandom_range(0, 99) < bias);
      endcase
    end
  endtask

  // Expected outcome from the stream: first prefix length where the answer is settled.
  task automatic model(input int t, input bit et, output int eo, output int ec,
                       output int ed, output int ee);
    int total;
    total = 0;
    eo = 0; ec = 0; ed = 0; ee = 0;
    for (int n = 1; n <= LEN; n++) begin
      total += int'(bits[n-1]);
      if ((et && (total > t)) || (et && (total + (LEN - n) <= t)) || (n == LEN)) begin
        eo = total;
        ec = n;
        ed = (total > t) ? 1 : 0;
        ee = (n < LEN) ? 1 : 0;
        return;
      end
    end
  endtask

  // stall: 0 always valid, 1 toggling valid starting with 1, 2 random valid
  task automatic measure(input string tag, input int t, input int stall, input bit poke,
                         output int r_ones, output int r_cycles, output int r_dec,
                         output int r_early, output int r_idx);
    bit got;
    bit v;
    int idx;
    start  = 1'b1;
    thresh = CW'(t);
    x_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, int'(o_busy), 1);
    idx = 0;
    got = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      case (stall)
        0:       v = 1'b1;
        1:       v = (c % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      x_valid = v;
      x       = (idx < 256) ? bits[idx] : 1'b0;
      start   = poke && (c == 20);
      @(negedge clk);
      if (v) idx++;
      if (o_done) begin
        got = 1'b1;
        break;
      end
    end
    start   = 1'b0;
    x_valid = 1'b0;
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_busy_in_done"}, int'(o_busy), 0);
    r_ones   = int'(o_ones);
    r_cycles = int'(o_cycles);
    r_dec    = int'(o_dec);
    r_early  = int'(o_early);
    r_idx    = idx;
    @(negedge clk);
    chk({tag, "_done_width"}, int'(o_done), 0);
    chk({tag, "_ones_hold"}, int'(o_ones), r_ones);
  endtask

  vec_t vecs [$];

  initial begin
    int ro, rc, rd, re, ri;
    int eo, ec, ed, ee;
    bit seen;
    vec_t v;
    string tag;

    n_checks = 0;
    n_errors = 0;
    sel = 1'b0; start = 1'b0; thresh = '0; x = 1'b0; x_valid = 1'b0;
    rst_n = 1'b0;

    vecs.push_back('{127, 0, 0, 1'b0, 1'b0, 128, 128, 1, 1});
    vecs.push_back('{127, 1, 0, 1'b0, 1'b0,   0, 128, 0, 1});
    vecs.push_back('{127, 2, 0, 1'b0, 1'b0, 128, 255, 1, 0});
    vecs.push_back('{127, 0, 0, 1'b1, 1'b1, 255, 255, 1, 0});
    vecs.push_back('{ 10, 0, 1, 1'b0, 1'b0,  11,  11, 1, 1});
    vecs.push_back('{255, 0, 0, 1'b0, 1'b0,   1,   1, 0, 1});
    vecs.push_back('{  0, 1, 0, 1'b0, 1'b0,   0, 255, 0, 0});
    vecs.push_back('{254, 1, 0, 1'b0, 1'b0,   0,   1, 0, 1});
    vecs.push_back('{254, 0, 1, 1'b0, 1'b0, 255, 255, 1, 0});
    vecs.push_back('{127, 1, 0, 1'b1, 1'b0,   0, 255, 0, 0});
    vecs.push_back('{127, 2, 1, 1'b1, 1'b0, 128, 255, 1, 0});

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      chk($sformatf("reset_busy_d%0d", d), int'(o_busy), 0);
      chk($sformatf("reset_done_d%0d", d), int'(o_done), 0);
      chk($sformatf("reset_dec_d%0d", d), int'(o_dec), 0);
      chk($sformatf("reset_early_d%0d", d), int'(o_early), 0);
      chk($sformatf("reset_ones_d%0d", d), int'(o_ones), 0);
      chk($sformatf("reset_cycles_d%0d", d), int'(o_cycles), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      v = vecs[i];
      tag = $sformatf("vec%0d", i);
      sel = v.dut;
      fill(v.pat);
      measure(tag, v.t, v.stall, v.poke, ro, rc, rd, re, ri);
      chk({tag, "_ones"}, ro, v.e_ones);
      chk({tag, "_cycles"}, rc, v.e_cycles);
      chk({tag, "_decision"}, rd, v.e_dec);
      chk({tag, "_early"}, re, v.e_early);
      chk({tag, "_consumed"}, ri, v.e_cycles);
    end

    // Reset in the middle of a run: everything clears and no done pulse appears.
    sel = 1'b0;
    fill(0);
    start = 1'b1; thresh = CW'(127); x_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      x = 1'b1; x_valid = 1'b1;
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    x_valid = 1'b0;
    chk("midrst_no_early_done", int'(seen), 0);
    chk("midrst_ones_before", int'(o_ones), 50);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", int'(o_busy), 0);
    chk("midrst_ones", int'(o_ones), 0);
    chk("midrst_cycles", int'(o_cycles), 0);
    chk("midrst_done", int'(o_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_done_after", int'(o_done), 0);
    chk("midrst_idle", int'(o_busy), 0);
    fill(3);
    bits[0] = 1'b1;
    measure("postrst", 0, 0, 1'b0, ro, rc, rd, re, ri);
    chk("postrst_decision", rd, 1);
    chk("postrst_cycles", rc, 1);
    chk("postrst_ones", ro, 1);
    chk("postrst_early", re, 1);

    // Randomized runs against the prefix-count model, both DUT variants, random stalls.
    for (int r = 0; r < 30; r++) begin
      sel = 1'($urandom_range(0, 1));
      fill(3);
      thresh = '0;
      tag = $sformatf("rnd%0d", r);
      ed = $urandom_range(0, 255);
      model(ed, (sel == 1'b0), eo, ec, ed, ee);
      ri = $urandom_range(0, 255);
      model(ri, (sel == 1'b0), eo, ec, ed, ee);
      measure(tag, ri, 2, 1'b0, ro, rc, rd, re, ri);
      chk({tag, "_ones"}, ro, eo);
      chk({tag, "_cycles"}, rc, ec);
      chk({tag, "_decision"}, rd, ed);
      chk({tag, "_early"}, re, ee);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
